// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART register map, status bit positions, FSM states and divisor helper
package uart_pkg;

    localparam logic [2:0] UART_REG_DATA   = 3'd0;
    localparam logic [2:0] UART_REG_STATUS = 3'd5;

    localparam int UART_ST_DR   = 0;
    localparam int UART_ST_OE   = 1;
    localparam int UART_ST_FE   = 3;
    localparam int UART_ST_THRE = 5;
    localparam int UART_ST_TEMT = 6;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} uart_tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;

    function automatic int uart_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - synchronous byte FIFO; push is accepted when full only if a pop happens too
module uart_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_mmio_device.sv
// rtl/uart_mmio_device.sv - device-side UART: THR + TX shifter, RX deserialiser into FIFO, DATA/STATUS registers
module uart_mmio_device
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 90_000_000,
    parameter int BAUD          = 1_152_000,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       txd,
    input  logic       bus_req,
    input  logic       bus_we,
    input  logic [2:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_ack
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD);
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] BIT_RELOAD  = TW'(DIV - 1);
    localparam logic [TW-1:0] HALF_RELOAD = TW'(DIV / 2 - 1);

    uart_tx_state_t tx_state;
    logic [TW-1:0]  tx_timer;
    logic [2:0]     tx_bit;
    logic [7:0]     tx_shift;
    logic [7:0]     thr;
    logic           thr_full;
    logic           tx_tick;
    logic           thr_take;

    uart_rx_state_t rx_state;
    logic [TW-1:0]  rx_timer;
    logic [2:0]     rx_bit;
    logic [7:0]     rx_shift;
    logic           rx_s1, rx_s2, rx_prev;
    logic           rx_tick, stop_sample;

    logic [7:0] fifo_head, status, rd_value;
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic       oe, fe, set_oe, set_fe, stat_clr, wr_data, accept;

    assign tx_tick  = (tx_timer == '0);
    assign thr_take = thr_full && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_tick));

    // txd is registered and updated alongside each state change so it never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
        end else if (tx_state == TX_IDLE) begin
            if (thr_full) begin
                tx_shift <= thr;
                tx_timer <= BIT_RELOAD;
                tx_state <= TX_START;
                txd      <= 1'b0;
            end
        end else if (!tx_tick) begin
            tx_timer <= tx_timer - 1'b1;
        end else begin
            tx_timer <= BIT_RELOAD;
            if (tx_state == TX_START) begin
                tx_state <= TX_DATA;
                tx_bit   <= '0;
                txd      <= tx_shift[0];
            end else if (tx_state == TX_DATA) begin
                tx_shift <= tx_shift >> 1;
                if (tx_bit == 3'd7) begin
                    tx_state <= TX_STOP;
                    txd      <= 1'b1;
                end else begin
                    tx_bit <= tx_bit + 1'b1;
                    txd    <= tx_shift[1];
                end
            end else if (thr_full) begin
                tx_shift <= thr;
                tx_state <= TX_START;
                txd      <= 1'b0;
            end else begin
                tx_state <= TX_IDLE;
                txd      <= 1'b1;
            end
        end
    end

    assign rx_tick     = (rx_timer == '0);
    assign stop_sample = (rx_state == RX_STOP) && rx_tick;
    assign fifo_push   = stop_sample && rx_s2;
    assign set_oe      = stop_sample && rx_s2 && fifo_full && !fifo_pop;
    assign set_fe      = stop_sample && !rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_timer <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_state == RX_IDLE) begin
                if (rx_prev && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_timer <= HALF_RELOAD;
                end
            end else if (!rx_tick) begin
                rx_timer <= rx_timer - 1'b1;
            end else begin
                rx_timer <= BIT_RELOAD;
                if (rx_state == RX_START) begin
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    rx_bit   <= '0;
                end else if (rx_state == RX_DATA) begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end else begin
                    rx_state <= RX_IDLE;
                end
            end
        end
    end

    uart_byte_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (rx_shift),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status                 = 8'h00;
        status[UART_ST_DR]     = !fifo_empty;
        status[UART_ST_OE]     = oe;
        status[UART_ST_FE]     = fe;
        status[UART_ST_THRE]   = !thr_full;
        status[UART_ST_TEMT]   = !thr_full && (tx_state == TX_IDLE);
    end

    always_comb begin
        rd_value = 8'h00;
        if (!bus_we) begin
            if (bus_addr == UART_REG_DATA && !fifo_empty) rd_value = fifo_head;
            else if (bus_addr == UART_REG_STATUS)         rd_value = status;
        end
    end

    // the !bus_ack guard keeps a request still high in its ack cycle from being taken twice
    assign wr_data  = bus_we && (bus_addr == UART_REG_DATA);
    assign accept   = bus_req && !bus_ack && !(wr_data && thr_full);
    assign fifo_pop = accept && !bus_we && (bus_addr == UART_REG_DATA) && !fifo_empty;
    assign stat_clr = accept && !bus_we && (bus_addr == UART_REG_STATUS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ack   <= 1'b0;
            bus_rdata <= 8'h00;
            thr       <= 8'h00;
            thr_full  <= 1'b0;
            oe        <= 1'b0;
            fe        <= 1'b0;
        end else begin
            bus_ack   <= accept;
            bus_rdata <= accept ? rd_value : 8'h00;
            if (accept && wr_data) begin
                thr      <= bus_wdata;
                thr_full <= 1'b1;
            end else if (thr_take) begin
                thr_full <= 1'b0;
            end
            oe <= set_oe || (oe && !stat_clr);
            fe <= set_fe || (fe && !stat_clr);
        end
    end

endmodule

// File: tb/tb_uart_mmio_device.sv
// tb/tb_uart_mmio_device.sv - self-checking bench for uart_mmio_device with an RX FIFO/flag model
module tb_uart_mmio_device;

    localparam int DIV   = 78;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       txd;
    logic       bus_req = 1'b0;
    logic       bus_we = 1'b0;
    logic [2:0] bus_addr = 3'd0;
    logic [7:0] bus_wdata = 8'h00;
    logic [7:0] bus_rdata;
    logic       bus_ack;

    uart_mmio_device dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .txd       (txd),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       exp_oe = 1'b0;
    logic       exp_fe = 1'b0;
    logic       cur_we = 1'b0;
    logic [2:0] cur_addr = 3'd0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s got=%0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Model: RX FIFO contents and sticky flags as the line protocol dictates
    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus_ack) begin
                check("idle_rdata", bus_rdata, 0);
            end else if (cur_we) begin
                check("ack_wr_rdata", bus_rdata, 0);
            end else if (cur_addr == 3'd0) begin
                if (exp_q.size() == 0) begin
                    check("model_rd_empty", bus_rdata, 0);
                end else begin
                    check("model_rd_data", bus_rdata, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end else if (cur_addr == 3'd5) begin
                check("model_status", bus_rdata & 8'h9F,
                      (exp_q.size() != 0 ? 1 : 0) + (exp_oe ? 2 : 0) + (exp_fe ? 8 : 0));
                exp_oe = 1'b0;
                exp_fe = 1'b0;
            end else begin
                check("model_rd_other", bus_rdata, 0);
            end
        end
    end

    task automatic bus_access(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                              output logic [7:0] rd, output int lat);
        @(negedge clk);
        cur_we    = we;
        cur_addr  = addr;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        bus_req   = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_ack && lat < 2000);
        check("bus_ack_arrived", bus_ack, 1);
        rd = bus_rdata;
        bus_req = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] addr, input logic [7:0] exp, input string name);
        logic [7:0] rd;
        int lat;
        bus_access(1'b0, addr, 8'h00, rd, lat);
        check(name, rd, exp);
        check({name, "_lat"}, lat, 1);
    endtask

    task automatic wr_reg(input logic [2:0] addr, input logic [7:0] wd, input string name);
        logic [7:0] rd;
        int lat;
        bus_access(1'b1, addr, wd, rd, lat);
        check({name, "_lat"}, lat, 1);
    endtask

    task automatic wait_txd_fall(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (txd && n < 3000);
        check("txd_fall_seen", txd, 0);
    endtask

    // Starts pre cycles before the start-bit centre and ends on the stop-bit centre
    task automatic tx_frame(input logic [7:0] b, input int pre);
        repeat (pre) @(negedge clk);
        check("tx_start_bit", txd, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            check($sformatf("tx_bit%0d_of_%02h", i, b), txd, b[i]);
        end
        repeat (DIV) @(negedge clk);
        check("tx_stop_bit", txd, 1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        if (!stop)                    exp_fe = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                          exp_oe = 1'b1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog cycles=%0d limit=50000", cyc);
        $fatal(1);
    end

    initial begin
        int n, fall_cyc, l1, l2, l3, n2;
        logic [7:0] r1, r2, r3;

        repeat (3) @(negedge clk);
        check("reset_txd", txd, 1);
        check("reset_ack", bus_ack, 0);
        check("reset_rdata", bus_rdata, 0);
        rst_n = 1'b1;

        rd_reg(3'd5, 8'h60, "status_reset");
        wr_reg(3'd3, 8'hFF, "wr_off3");
        rd_reg(3'd3, 8'h00, "rd_off3");
        rd_reg(3'd5, 8'h60, "status_after_off3");

        wr_reg(3'd0, 8'hA5, "wr_a5");
        wait_txd_fall(n);
        fall_cyc = cyc;
        check_range("txd_low_after_ack", n, 1, 2);
        tx_frame(8'hA5, DIV / 2);
        while (cyc < fall_cyc + 778) @(negedge clk);
        rd_reg(3'd5, 8'h20, "temt_busy_779");
        rd_reg(3'd5, 8'h60, "temt_done_781");

        fork
            begin
                bus_access(1'b1, 3'd0, 8'h55, r1, l1);
                check("wr55_lat", l1, 1);
                bus_access(1'b1, 3'd0, 8'h0F, r2, l2);
                check("wr0f_lat", l2, 1);
                bus_access(1'b1, 3'd0, 8'hC3, r3, l3);
                check_range("wrc3_stall_lat", l3, 770, 785);
            end
            begin
                wait_txd_fall(n2);
                tx_frame(8'h55, DIV / 2);
                tx_frame(8'h0F, DIV);
                tx_frame(8'hC3, DIV);
            end
        join
        repeat (DIV) @(negedge clk);
        rd_reg(3'd5, 8'h60, "status_tx_drained");

        rx_frame(8'h3C, 1'b1);
        rd_reg(3'd5, 8'h61, "rx3c_status_dr");
        rd_reg(3'd0, 8'h3C, "rx3c_data");
        rd_reg(3'd5, 8'h60, "rx3c_status_empty");

        for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1);
        for (int i = 1; i <= 4; i++) rd_reg(3'd0, 8'(i), $sformatf("ovr_data%0d", i));
        rd_reg(3'd0, 8'h00, "ovr_data_empty");
        rd_reg(3'd5, 8'h62, "ovr_status_oe");
        rd_reg(3'd5, 8'h60, "ovr_status_cleared");

        rx_frame(8'h77, 1'b0);
        rd_reg(3'd5, 8'h68, "fe_status");
        rd_reg(3'd5, 8'h60, "fe_status_cleared");
        rd_reg(3'd0, 8'h00, "fe_no_data");

        rxd = 1'b0;
        repeat (23) @(negedge clk);
        rxd = 1'b1;
        repeat (10 * DIV) @(negedge clk);
        rd_reg(3'd5, 8'h60, "glitch_status");
        rd_reg(3'd0, 8'h00, "glitch_no_data");

        wr_reg(3'd0, 8'h81, "wr_81");
        wait_txd_fall(n);
        repeat (10) @(negedge clk);
        check("txd_start_before_reset", txd, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("txd_async_reset", txd, 1);
        check("ack_async_reset", bus_ack, 0);
        exp_q.delete();
        exp_oe = 1'b0;
        exp_fe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check("txd_idle_after_reset", txd, 1);
        rd_reg(3'd5, 8'h60, "thre_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
